// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud/width helpers,
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int unsigned BITS_PER_BYTE = 8;

  // Clocks per serial bit, integer truncation.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned bps);
    return clk_freq / bps;
  endfunction

  // Counter width for n states, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 and pulses bit_done on the last cycle
// of each serial bit; clear holds it at zero so a frame always starts aligned.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 66
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_done = !clear && (r_cnt == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// Reads words from a standard (non-FWFT) FIFO and sends each one as
// FIFO_RD_BYTE back-to-back 8N1 frames, most-significant byte first.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned UART_BPS      = 1_500_000,
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned FIFO_RD_WIDTH = 32,
  parameter int unsigned FIFO_RD_BYTE  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  input  logic [FIFO_RD_WIDTH-1:0] fifo_rd_data,
  output logic                     fifo_rd_en,
  output logic                     tx,
  output logic                     busy
);

  localparam int unsigned DIV   = baud_div(CLK_FREQ, UART_BPS);
  localparam int unsigned IDX_W = cnt_width(FIFO_RD_BYTE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FIFO_RD_BYTE - 1);

  uart_state_t              r_state, w_state_nxt;
  logic [2:0]               r_bit, w_bit_nxt;
  logic [IDX_W-1:0]         r_idx, w_idx_nxt;
  logic [FIFO_RD_WIDTH-1:0] r_word, w_word_nxt;
  logic [FIFO_RD_WIDTH-1:0] w_shifted;
  logic [7:0]               w_byte;
  logic                     r_rd_en, w_rd_en_nxt;
  logic                     r_tx, w_tx_nxt;
  logic                     w_clear, w_bit_done;

  assign w_clear = (r_state == IDLE) || (r_state == FETCH) || (r_state == LOAD);

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_clear),
    .bit_done(w_bit_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_idx_nxt   = r_idx;
    w_word_nxt  = r_word;
    w_rd_en_nxt = 1'b0;
    w_tx_nxt    = 1'b1;
    w_shifted   = '0;
    w_byte      = '0;

    case (r_state)
      IDLE: begin
        if (!fifo_empty) begin
          w_state_nxt = FETCH;
          w_rd_en_nxt = 1'b1;
        end
      end
      FETCH: w_state_nxt = LOAD;
      LOAD: begin
        w_word_nxt  = fifo_rd_data;
        w_idx_nxt   = '0;
        w_bit_nxt   = '0;
        w_state_nxt = START;
      end
      START: begin
        if (w_bit_done) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_bit_done) begin
          if (r_idx < IDX_LAST) begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // tx is registered, so the line level is chosen from the state being entered.
    w_shifted = w_word_nxt << {w_idx_nxt, 3'b000};
    w_byte    = w_shifted[FIFO_RD_WIDTH-1 -: 8];
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_byte[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_idx   <= '0;
      r_word  <= '0;
      r_rd_en <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_idx   <= w_idx_nxt;
      r_word  <= w_word_nxt;
      r_rd_en <= w_rd_en_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  assign fifo_rd_en = r_rd_en;
  assign tx         = r_tx;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter at DIV=8: FIFO model, frame-timeline reference
// model checked every cycle, tx line decoder, and directed literal checks.
module tb_uart_transmitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;

  always #5 clk = ~clk;

  uart_transmitter #(
    .UART_BPS     (1),
    .CLK_FREQ     (8),
    .FIFO_RD_WIDTH(32),
    .FIFO_RD_BYTE (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .tx          (tx),
    .busy        (busy)
  );

  // Standard-mode FIFO: data appears the cycle after the read request.
  logic [31:0] mem [0:255];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (fifo_rd_en && (rd_cnt != wr_cnt)) begin
      fifo_rd_data <= mem[rd_cnt];
      rd_cnt       <= rd_cnt + 1;
    end
  end

  int cyc = 0;
  bit rst_s = 1'b1;
  bit empty_s = 1'b1;
  always @(posedge clk) begin
    cyc     = cyc + 1;
    rst_s   = rst;
    empty_s = fifo_empty;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: a word occupies rd cycle, load cycle, then 4 frames of 80 cycles.
  function automatic logic frame_bit(input logic [31:0] w, input int k);
    int b;
    int s;
    logic [7:0] by;
    b  = k / 80;
    s  = (k % 80) / 8;
    by = 8'(w >> (8 * (3 - b)));
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return by[s-1];
  endfunction

  bit          m_active = 1'b0;
  int          m_rd = 0;
  int          m_widx = 0;
  int          m_k;
  logic [31:0] m_word = '0;
  logic        e_tx, e_busy, e_rd;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst_s) begin
        m_active = 1'b0;
      end else if (!m_active && !empty_s) begin
        m_active = 1'b1;
        m_rd     = cyc;
        m_word   = mem[m_widx];
        m_widx++;
      end else if (m_active && (cyc - m_rd - 2) >= 320) begin
        m_active = 1'b0;
      end
      m_k = cyc - m_rd - 2;
      if (!m_active) begin
        e_tx = 1'b1; e_busy = 1'b0; e_rd = 1'b0;
      end else begin
        e_busy = 1'b1;
        e_rd   = (m_k == -2);
        e_tx   = (m_k < 0) ? 1'b1 : frame_bit(m_word, m_k);
      end
      chk("cycle_tx_busy_rden", {29'd0, tx, busy, fifo_rd_en}, {29'd0, e_tx, e_busy, e_rd});
    end
  end

  // Line decoder: sample mid-bit, 8 cycles per bit.
  logic [7:0] rx_q[$];
  int frame_err = 0;
  logic [7:0] rx_b;
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(negedge clk);
          rx_b[i] = tx;
        end
        repeat (8) @(negedge clk);
        if (tx !== 1'b1) frame_err++;
        rx_q.push_back(rx_b);
      end
    end
  end

  task automatic wait_sig(input string name, input int which, input logic val,
                          input int budget, output int at);
    logic s;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      s = (which == 0) ? fifo_rd_en : (which == 1) ? tx : busy;
      if (s === val) begin
        at = cyc;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL timeout_%s cycle=%0d actual=none required=%0b", name, cyc, val);
  endtask

  task automatic chk_rx(input string name, input logic [7:0] exp);
    if (rx_q.size() == 0) begin
      chk(name, 32'hDEAD, {24'd0, exp});
    end else begin
      chk(name, {24'd0, rx_q.pop_front()}, {24'd0, exp});
    end
  endtask

  int p, t_rd, t_tx, t_b, r1, r2, tmp, base;
  logic [31:0] got;
  logic [7:0] exp_a [0:3];

  initial begin
    exp_a[0] = 8'hA5; exp_a[1] = 8'hC3; exp_a[2] = 8'h0F; exp_a[3] = 8'h81;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rden", {31'd0, fifo_rd_en}, 32'd0);
    rst = 1'b0;

    repeat (1000) @(negedge clk);
    chk("idle_no_read", rd_cnt, 0);
    chk("idle_tx", {31'd0, tx}, 32'd1);

    // Single word
    mem[wr_cnt] = 32'hA5C3_0F81;
    p = cyc;
    wr_cnt++;
    wait_sig("rden1", 0, 1'b1, 10, t_rd);
    chk("rden_latency", t_rd - p, 1);
    @(negedge clk);
    chk("rden_width", {31'd0, fifo_rd_en}, 32'd0);
    wait_sig("txlow1", 1, 1'b0, 10, t_tx);
    chk("tx_start_latency", t_tx - t_rd, 2);
    wait_sig("busy1", 2, 1'b0, 400, t_b);
    chk("frames_length", t_b - t_tx, 320);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_rx("word1_byte", exp_a[i]);

    // Two words back to back
    mem[wr_cnt]     = 32'h0000_0000;
    mem[wr_cnt + 1] = 32'hFFFF_FFFF;
    wr_cnt += 2;
    wait_sig("rden2a", 0, 1'b1, 10, r1);
    wait_sig("rden2a_low", 0, 1'b0, 10, tmp);
    wait_sig("rden2b", 0, 1'b1, 400, r2);
    chk("second_read_spacing", r2 - r1, 323);
    wait_sig("busy2", 2, 1'b0, 400, tmp);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_rx("zero_byte", 8'h00);
    for (int i = 0; i < 4; i++) chk_rx("ones_byte", 8'hFF);

    // Reset mid-word
    mem[wr_cnt] = 32'h1234_5678;
    wr_cnt++;
    wait_sig("rden3", 0, 1'b1, 10, r1);
    repeat (102) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rden", {31'd0, fifo_rd_en}, 32'd0);
    repeat (200) @(negedge clk);
    chk("abort_reads", rd_cnt, 4);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    rx_q.delete();
    mem[wr_cnt] = 32'h5A5A_1234;
    p = cyc;
    wr_cnt++;
    wait_sig("rden4", 0, 1'b1, 10, t_rd);
    chk("post_reset_latency", t_rd - p, 1);
    wait_sig("busy4", 2, 1'b0, 400, tmp);
    repeat (10) @(negedge clk);
    chk_rx("post_reset_byte", 8'h5A);
    chk_rx("post_reset_byte", 8'h5A);
    chk_rx("post_reset_byte", 8'h12);
    chk_rx("post_reset_byte", 8'h34);

    // Loopback of random words
    base = wr_cnt;
    for (int i = 0; i < 64; i++) mem[base + i] = $urandom;
    wr_cnt += 64;
    tmp = 0;
    for (int i = 0; i < 64 * 330 + 100; i++) begin
      @(negedge clk);
      if (rd_cnt == wr_cnt && busy == 1'b0) begin
        tmp = 1;
        break;
      end
    end
    chk("loopback_done", tmp, 1);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      got = '0;
      for (int j = 0; j < 4; j++) begin
        got = got << 8;
        if (rx_q.size() != 0) got[7:0] = rx_q.pop_front();
      end
      chk("loopback_word", got, mem[base + i]);
    end
    chk("rx_leftover", rx_q.size(), 0);
    chk("framing_errors", frame_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
